// File: rtl/nios2_debug_cmd_sequencer.sv
// nios2_debug_cmd_sequencer
//
// Sysclk-domain sequencer between the JTAG debug slave's action strobes and
// the OCI command port. Strobed actions are queued as {type, jdo} in a small
// FIFO and presented one at a time over a valid/ready handshake. After a
// monitor "go" command (OCIMEM_A with data[35] set) the next command is held
// off until the monitor reports ready, reports an error, or the wait times out.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   take_action_*           single-cycle action strobes (six command types)
//   jdo[37:0]               JTAG data, valid in the strobe cycle
//   monitor_ready/error     monitor status levels, sampled while waiting
//   oci_cmd_ready           OCI accepts the presented command
//   err_clr                 clears the sticky flags (a same-cycle set wins)
//   oci_cmd_valid/type/data registered command presented to the OCI
//   busy                    FSM not idle or FIFO non-empty
//   fifo_count[4:0]         occupied FIFO entries (includes the one in flight)
//   overflow                sticky: a strobe was dropped
//   seq_error               sticky: monitor_error seen while waiting
//   mon_timeout             sticky: monitor wait timed out
module nios2_debug_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MON_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_action_break_a,
    input  logic        take_action_break_b,
    input  logic        take_action_break_c,
    input  logic        take_action_tracectrl,
    input  logic [37:0] jdo,
    input  logic        monitor_ready,
    input  logic        monitor_error,
    input  logic        oci_cmd_ready,
    input  logic        err_clr,
    output logic        oci_cmd_valid,
    output logic [2:0]  oci_cmd_type,
    output logic [37:0] oci_cmd_data,
    output logic        busy,
    output logic [4:0]  fifo_count,
    output logic        overflow,
    output logic        seq_error,
    output logic        mon_timeout
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);
    localparam logic [15:0] WAIT_LAST = 16'(MON_TIMEOUT - 1);

    typedef enum logic [2:0] {
        CMD_OCIMEM_A  = 3'd0,
        CMD_OCIMEM_B  = 3'd1,
        CMD_BREAK_A   = 3'd2,
        CMD_BREAK_B   = 3'd3,
        CMD_BREAK_C   = 3'd4,
        CMD_TRACECTRL = 3'd5
    } cmd_type_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_MON
    } state_t;

    typedef struct packed {
        logic [2:0]  cmd_type;
        logic [37:0] cmd_data;
    } entry_t;

    state_t             state;
    logic [15:0]        wait_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    entry_t             mem [FIFO_DEPTH];
    entry_t             head;

    logic [5:0]         strobes;
    logic [2:0]         push_type;
    logic               push_req;
    logic               push_multi;
    logic               push_ok;
    logic               push_drop;
    logic               pop;
    logic               seq_set;
    logic               timeout_set;

    // Bit position equals the command type code.
    assign strobes = {take_action_tracectrl, take_action_break_c, take_action_break_b,
                      take_action_break_a, take_action_ocimem_b, take_action_ocimem_a};

    // Lowest type code wins: scan from the top so the lowest set bit is written last.
    // NOTE: push_type gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        push_type = '0;
        for (int i = 5; i >= 0; i--) begin
            if (strobes[i]) push_type = 3'(i);
        end
    end

    assign push_req   = |strobes;
    assign push_multi = |(strobes & (strobes - 6'd1));   // more than one strobe set
    assign pop        = oci_cmd_valid & oci_cmd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok    = push_req & ((fifo_count < DEPTH_C) | pop);
    assign push_drop  = push_multi | (push_req & ~push_ok);
    assign head       = mem[rd_ptr];

    assign seq_set     = (state == ST_WAIT_MON) & monitor_error;
    assign timeout_set = (state == ST_WAIT_MON) & ~monitor_error & ~monitor_ready &
                         (wait_cnt == WAIT_LAST);

    assign busy = (state != ST_IDLE) | (fifo_count != 5'd0);

    // NOTE: storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= '{cmd_type: push_type, cmd_data: jdo};
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + {4'd0, push_ok} - {4'd0, pop};
        end
    end

    // Command FSM with registered command outputs and sticky flags.
    // The head entry stays in the FIFO until its handshake; the output
    // registers hold a copy so type/data stay stable while presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            oci_cmd_valid <= 1'b0;
            oci_cmd_type  <= '0;
            oci_cmd_data  <= '0;
            overflow      <= 1'b0;
            seq_error     <= 1'b0;
            mon_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_count != 5'd0) begin
                        oci_cmd_valid <= 1'b1;
                        oci_cmd_type  <= head.cmd_type;
                        oci_cmd_data  <= head.cmd_data;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Valid is only dropped on a handshake.
                    if (pop) begin
                        oci_cmd_valid <= 1'b0;
                        if (oci_cmd_type == CMD_OCIMEM_A && oci_cmd_data[35]) begin
                            wait_cnt <= '0;
                            state    <= ST_WAIT_MON;
                        end else begin
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_MON: begin
                    if (monitor_error || monitor_ready || wait_cnt == WAIT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Set wins over a same-cycle clear.
            overflow    <= push_drop   | (overflow    & ~err_clr);
            seq_error   <= seq_set     | (seq_error   & ~err_clr);
            mon_timeout <= timeout_set | (mon_timeout & ~err_clr);
        end
    end

endmodule

// File: tb/tb_nios2_debug_cmd_sequencer.sv
// Self-checking bench for nios2_debug_cmd_sequencer: a table of single-action
// vectors, hand-written multi-cycle sequences (FIFO saturation, monitor go with
// ready/error/timeout, sticky-flag clearing, asynchronous reset), and a
// randomized run checked every cycle against a queue-based reference model.
module tb_nios2_debug_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 24;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  stb = '0;
    logic [37:0] jdo = '0;
    logic        monitor_ready = 1'b0;
    logic        monitor_error = 1'b0;
    logic        oci_cmd_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        oci_cmd_valid;
    logic [2:0]  oci_cmd_type;
    logic [37:0] oci_cmd_data;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        seq_error;
    logic        mon_timeout;

    nios2_debug_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .MON_TIMEOUT(TO)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .take_action_ocimem_a  (stb[0]),
        .take_action_ocimem_b  (stb[1]),
        .take_action_break_a   (stb[2]),
        .take_action_break_b   (stb[3]),
        .take_action_break_c   (stb[4]),
        .take_action_tracectrl (stb[5]),
        .jdo                   (jdo),
        .monitor_ready         (monitor_ready),
        .monitor_error         (monitor_error),
        .oci_cmd_ready         (oci_cmd_ready),
        .err_clr               (err_clr),
        .oci_cmd_valid         (oci_cmd_valid),
        .oci_cmd_type          (oci_cmd_type),
        .oci_cmd_data          (oci_cmd_data),
        .busy                  (busy),
        .fifo_count            (fifo_count),
        .overflow              (overflow),
        .seq_error             (seq_error),
        .mon_timeout           (mon_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [37:0] d;
    } cmd_t;

    typedef struct {
        logic [5:0]  stb;
        logic [37:0] jdo;
        logic [2:0]  exp_type;
        logic        exp_ovf;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: queue of live entries plus abstract phase flags.
    cmd_t mq[$];
    bit   m_pres, m_wait;
    int   m_waited;
    bit   m_ovf, m_serr, m_mto;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Each tick lands 1 time unit after the rising edge: outputs are settled
    // and inputs written here are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {oci_cmd_valid, oci_cmd_type, oci_cmd_data, fifo_count, busy,
                overflow, seq_error, mon_timeout};
    endfunction

    task automatic clear_flags();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Strobe a go command (OCIMEM_A, jdo[35]=1), optionally followed by a
    // TRACECTRL on the next cycle; returns in the handshake cycle M.
    task automatic send_go(input bit with_trace);
        stb = 6'b000001;
        jdo = 38'h08_0000_0001;
        tick();
        stb = with_trace ? 6'b100000 : 6'b000000;
        jdo = 38'h00_5555_aaaa;
        tick();
        stb = '0;
        check("go valid at N+2", {oci_cmd_valid, oci_cmd_type}, {1'b1, 3'd0});
    endtask

    // Reference-model step for one cycle, using the inputs currently driven.
    task automatic model_step();
        bit pop, accept, s_ovf, s_serr, s_mto;
        int n, sel;
        pop    = m_pres && oci_cmd_ready;
        n      = $countones(stb);
        sel    = 0;
        for (int i = 0; i < 6; i++) begin
            if (stb[i]) begin
                sel = i;
                break;
            end
        end
        s_ovf  = (n > 1);
        accept = (n > 0) && (mq.size() < DEPTH || pop);
        if (n > 0 && !accept) s_ovf = 1'b1;
        s_serr = 1'b0;
        s_mto  = 1'b0;
        if (m_pres) begin
            if (pop) begin
                m_pres   = 1'b0;
                m_wait   = (mq[0].t == 3'd0) && mq[0].d[35];
                m_waited = 0;
            end
        end else if (m_wait) begin
            if (monitor_error) begin
                s_serr = 1'b1;
                m_wait = 1'b0;
            end else if (monitor_ready) begin
                m_wait = 1'b0;
            end else if (m_waited == TO - 1) begin
                s_mto  = 1'b1;
                m_wait = 1'b0;
            end else begin
                m_waited++;
            end
        end else if (mq.size() != 0) begin
            m_pres = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (accept) mq.push_back(cmd_t'{t: 3'(sel), d: jdo});
        m_ovf  = s_ovf  | (m_ovf  & ~err_clr);
        m_serr = s_serr | (m_serr & ~err_clr);
        m_mto  = s_mto  | (m_mto  & ~err_clr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        cmd_t        got[$];
        cmd_t        exp_cmd;
        logic [2:0]  six_t[6];
        bit          seen;

        vecs[0] = '{stb: 6'b001000, jdo: 38'h02_1234_5678, exp_type: 3'd3, exp_ovf: 1'b0};
        vecs[1] = '{stb: 6'b100010, jdo: 38'h00_0000_00a5, exp_type: 3'd1, exp_ovf: 1'b1};
        vecs[2] = '{stb: 6'b000001, jdo: 38'h00_dead_beef, exp_type: 3'd0, exp_ovf: 1'b0};
        vecs[3] = '{stb: 6'b110100, jdo: 38'h03_0f0f_0f0f, exp_type: 3'd2, exp_ovf: 1'b1};
        vecs[4] = '{stb: 6'b100000, jdo: 38'h01_ffff_ffff, exp_type: 3'd5, exp_ovf: 1'b0};
        vecs[5] = '{stb: 6'b010000, jdo: 38'h3f_ffff_ffff, exp_type: 3'd4, exp_ovf: 1'b0};

        // ---------------- reset values ----------------
        tick();
        tick();
        check("outputs in reset", all_outs(), 64'd0);
        reset_n = 1'b1;
        tick();
        check("outputs after release", all_outs(), 64'd0);

        // ---------------- table-driven single actions ----------------
        oci_cmd_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            clear_flags();                       // cycle N
            stb = vecs[v].stb;
            jdo = vecs[v].jdo;
            tick();                              // N+1
            stb = '0;
            jdo = 38'h15_5555_5555;
            check($sformatf("vec%0d count/valid N+1", v), {fifo_count, oci_cmd_valid}, {5'd1, 1'b0});
            tick();                              // N+2
            check($sformatf("vec%0d cmd N+2", v), {oci_cmd_valid, oci_cmd_type, oci_cmd_data},
                  {1'b1, vecs[v].exp_type, vecs[v].jdo});
            tick();                              // N+3
            check($sformatf("vec%0d valid N+3", v), oci_cmd_valid, 1'b0);
            check($sformatf("vec%0d overflow", v), overflow, vecs[v].exp_ovf);
            tick();                              // N+4
            check($sformatf("vec%0d busy/count N+4", v), {busy, fifo_count}, {1'b0, 5'd0});
        end

        // ---------------- six strobes into a depth-4 FIFO ----------------
        clear_flags();
        oci_cmd_ready = 1'b0;
        six_t = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
        for (int i = 0; i < 6; i++) begin
            stb = 6'(1 << six_t[i]);
            jdo = 38'h10 + 38'(i);
            tick();
        end
        stb = '0;
        check("six: count saturates", fifo_count, 5'd4);
        check("six: overflow", overflow, 1'b1);
        check("six: head presented", {oci_cmd_valid, oci_cmd_type, oci_cmd_data}, {1'b1, 3'd1, 38'h10});
        oci_cmd_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (oci_cmd_valid && oci_cmd_ready) got.push_back(cmd_t'{t: oci_cmd_type, d: oci_cmd_data});
            tick();
        end
        check("six: issued count", 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            exp_cmd = cmd_t'{t: six_t[i], d: 38'h10 + 38'(i)};
            if (i < got.size()) check($sformatf("six: issued #%0d", i), got[i], exp_cmd);
            else check($sformatf("six: issued #%0d missing", i), 64'd0, exp_cmd);
        end
        check("six: drained", {busy, fifo_count}, {1'b0, 5'd0});

        // ---------------- go command, monitor_ready after 20 cycles ----------------
        clear_flags();
        send_go(1'b1);                           // cycle M
        seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();                              // M+k
            if (oci_cmd_valid) seen = 1'b1;
            if (k == 20) begin
                check("go: trace still queued", {fifo_count, busy}, {5'd1, 1'b1});
                monitor_ready = 1'b1;
            end
        end
        check("go: no command while waiting", seen, 1'b0);
        tick();                                  // M+21
        monitor_ready = 1'b0;
        check("go: idle after ready", oci_cmd_valid, 1'b0);
        tick();                                  // M+22
        check("go: trace valid 2 after pulse", {oci_cmd_valid, oci_cmd_type, oci_cmd_data},
              {1'b1, 3'd5, 38'h00_5555_aaaa});
        tick();
        check("go: no flags", {seq_error, mon_timeout}, 2'b00);

        // ---------------- go command, silent monitor -> timeout ----------------
        send_go(1'b1);                           // cycle M
        for (int k = 1; k <= TO; k++) tick();    // M+TO: exit cycle
        check("timeout: flag not yet at exit cycle", {mon_timeout, oci_cmd_valid}, 2'b00);
        tick();                                  // M+TO+1
        check("timeout: flag set after exit", {mon_timeout, oci_cmd_valid}, 2'b10);
        tick();                                  // M+TO+2
        check("timeout: next command proceeds", {oci_cmd_valid, oci_cmd_type}, {1'b1, 3'd5});
        tick();
        clear_flags();
        check("timeout: err_clr clears", mon_timeout, 1'b0);

        // err_clr in the same cycle as the timeout set: set wins
        send_go(1'b0);
        for (int k = 1; k <= TO; k++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("timeout: set wins over err_clr", mon_timeout, 1'b1);
        clear_flags();
        check("timeout: later err_clr clears", mon_timeout, 1'b0);

        // ---------------- go command, monitor_error beats monitor_ready ----------------
        send_go(1'b0);
        for (int k = 1; k <= 3; k++) tick();
        monitor_error = 1'b1;
        monitor_ready = 1'b1;
        tick();
        monitor_error = 1'b0;
        monitor_ready = 1'b0;
        check("monerr: seq_error set, idle", {seq_error, mon_timeout, oci_cmd_valid, busy}, 4'b1000);
        clear_flags();
        check("monerr: err_clr clears", seq_error, 1'b0);

        // ---------------- asynchronous reset while issuing ----------------
        oci_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stb = 6'(1 << (i + 2));
            jdo = 38'h20 + 38'(i);
            tick();
        end
        stb = '0;
        check("rst: issuing with 3 queued", {oci_cmd_valid, fifo_count}, {1'b1, 5'd3});
        #1;
        reset_n = 1'b0;
        #1;
        check("rst: async clear", all_outs(), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        oci_cmd_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (oci_cmd_valid || fifo_count != 5'd0) seen = 1'b1;
        end
        check("rst: nothing issued after release", seen, 1'b0);
        stb = 6'b000100;
        jdo = 38'h2a_aaaa_aaaa;
        tick();
        stb = '0;
        tick();
        check("rst: new strobe issues", {oci_cmd_valid, oci_cmd_type, oci_cmd_data},
              {1'b1, 3'd2, 38'h2a_aaaa_aaaa});

        // ---------------- randomized run against the reference model ----------------
        reset_n = 1'b0;
        stb = '0;
        oci_cmd_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        mq.delete();
        m_pres = 1'b0; m_wait = 1'b0; m_waited = 0;
        m_ovf = 1'b0; m_serr = 1'b0; m_mto = 1'b0;
        for (int c = 0; c < 800; c++) begin
            int r;
            logic [63:0] exp_v, act_v;
            r = int'($urandom_range(99));
            if (r < 25)      stb = 6'(1 << $urandom_range(5));
            else if (r < 30) stb = 6'((1 << $urandom_range(5)) | (1 << $urandom_range(5)));
            else             stb = '0;
            jdo           = 38'({$urandom, $urandom});
            oci_cmd_ready = ($urandom_range(99) < 60);
            monitor_ready = ($urandom_range(99) < 8);
            monitor_error = ($urandom_range(99) < 3);
            err_clr       = ($urandom_range(99) < 4);
            exp_v = {m_pres, 5'(mq.size()), (m_pres | m_wait | (mq.size() != 0)), m_ovf, m_serr, m_mto,
                     m_pres ? mq[0].t : 3'd0, m_pres ? mq[0].d : 38'd0};
            act_v = {oci_cmd_valid, fifo_count, busy, overflow, seq_error, mon_timeout,
                     oci_cmd_valid ? oci_cmd_type : 3'd0, oci_cmd_valid ? oci_cmd_data : 38'd0};
            check($sformatf("random cycle %0d", c), act_v, exp_v);
            model_step();
            tick();
        end
        stb = '0;
        monitor_ready = 1'b0;
        monitor_error = 1'b0;
        err_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
